// File: rtl/regfile_param.sv
// regfile_param: dual-read, single-write register file with byte enables, bypass and a sweep-clear engine
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic [ADDR_W-1:0]   R_Addr_A,
  input  logic [ADDR_W-1:0]   R_Addr_B,
  output logic [DATA_W-1:0]   R_Data_A,
  output logic [DATA_W-1:0]   R_Data_B,
  input  logic                Write_Reg,
  input  logic [ADDR_W-1:0]   W_Addr,
  input  logic [DATA_W-1:0]   W_Data,
  input  logic [DATA_W/8-1:0] W_Byte_En,
  input  logic                Clear_Req,
  output logic                Busy,
  output logic                Wr_Drop
);
  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] ptr, ptr_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic wr_ok;
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old, input logic [DATA_W-1:0] d,
                                              input logic [NB-1:0] be);
    merge = old;
    for (int i = 0; i < NB; i++) if (be[i]) merge[8*i +: 8] = d[8*i +: 8];
  endfunction
  // writable/readable storage: inside the array and not the hardwired zero entry
  function automatic logic live(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_C) && !(ZERO_REG != 0 && a == '0);
  endfunction
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    return (Reset || !live(a)) ? '0 :
           (BYPASS != 0 && wr_ok && W_Addr == a) ? merge(mem[a], W_Data, W_Byte_En) : mem[a];
  endfunction
  assign Busy     = state == CLEAR;
  assign Wr_Drop  = Write_Reg && Busy;
  assign wr_ok    = Write_Reg && !Busy && live(W_Addr);
  assign R_Data_A = rd(R_Addr_A);
  assign R_Data_B = rd(R_Addr_B);
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    if (state == IDLE) begin
      state_nx = Clear_Req ? CLEAR : IDLE;
      ptr_nx   = '0;
    end else begin
      state_nx = (ptr == LAST) ? IDLE : CLEAR;
      ptr_nx   = (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (Busy) begin
      mem[ptr] <= '0;
    end else if (wr_ok) begin
      mem[W_Addr] <= merge(mem[W_Addr], W_Data, W_Byte_En);
    end
  end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed vectors across three parameter sets sharing one stimulus bus
module tb_regfile_param;
  logic clk = 0, rst_in = 1;
  logic [4:0] ra, rb, wa;
  logic [31:0] wd;
  logic [3:0] be;
  logic we, clr;
  logic [31:0] a0, b0, a1, b1, a2, b2;
  logic bz0, bz1, bz2, dr0, dr1, dr2;
  int n_cmp = 0, n_bad = 0;
  int cnt0, cnt2;

  always #5 clk = ~clk;

  regfile_param d0 (.clk(clk), .Reset(rst_in), .R_Addr_A(ra), .R_Addr_B(rb), .R_Data_A(a0), .R_Data_B(b0),
    .Write_Reg(we), .W_Addr(wa), .W_Data(wd), .W_Byte_En(be), .Clear_Req(clr), .Busy(bz0), .Wr_Drop(dr0));
  regfile_param #(.ZERO_REG(0), .BYPASS(0)) d1 (.clk(clk), .Reset(rst_in), .R_Addr_A(ra), .R_Addr_B(rb),
    .R_Data_A(a1), .R_Data_B(b1), .Write_Reg(we), .W_Addr(wa), .W_Data(wd), .W_Byte_En(be),
    .Clear_Req(clr), .Busy(bz1), .Wr_Drop(dr1));
  regfile_param #(.DEPTH(24)) d2 (.clk(clk), .Reset(rst_in), .R_Addr_A(ra), .R_Addr_B(rb),
    .R_Data_A(a2), .R_Data_B(b2), .Write_Reg(we), .W_Addr(wa), .W_Data(wd), .W_Byte_En(be),
    .Clear_Req(clr), .Busy(bz2), .Wr_Drop(dr2));

  typedef struct {
    logic we; logic [4:0] wa; logic [31:0] wd; logic [3:0] be; logic [4:0] ra, rb;
    logic [31:0] ea0, eb0, ea1, eb1;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input logic w, input logic [4:0] addr, input logic [31:0] d, input logic [3:0] e,
                      input logic c, input logic [4:0] x, input logic [4:0] y);
    @(negedge clk);
    we = w; wa = addr; wd = d; be = e; clr = c; ra = x; rb = y;
    #1;
  endtask

  initial begin
    vecs[0] = '{1, 3, 32'h11223344, 4'hF, 3, 0, 32'h11223344, 0, 0, 0};
    vecs[1] = '{1, 3, 32'hAABBCCDD, 4'h5, 3, 3, 32'h11BB33DD, 32'h11BB33DD, 32'h11223344, 32'h11223344};
    vecs[2] = '{0, 0, 0, 0, 3, 3, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD};
    vecs[3] = '{1, 0, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0, 0, 0};
    vecs[4] = '{0, 0, 0, 0, 0, 3, 0, 32'h11BB33DD, 32'hFFFFFFFF, 32'h11BB33DD};
    vecs[5] = '{1, 7, 32'h12345678, 4'h0, 7, 7, 0, 0, 0, 0};
    vecs[6] = '{1, 7, 32'hCAFEF00D, 4'h2, 7, 3, 32'h0000F000, 32'h11BB33DD, 0, 32'h11BB33DD};
    vecs[7] = '{0, 0, 0, 0, 7, 7, 32'h0000F000, 32'h0000F000, 32'h0000F000, 32'h0000F000};
    we = 0; wa = 0; wd = 0; be = 0; clr = 0; ra = 5; rb = 31;
    #3;
    chk("reset_busy", 32'(bz0), 0);
    chk("reset_drop", 32'(dr0), 0);
    chk("reset_rd_a", a0, 0);
    @(negedge clk); rst_in = 0;

    step(1, 5, 32'hDEADBEEF, 4'hF, 0, 5, 31);
    step(1, 31, 32'h31313131, 4'hF, 0, 5, 31);
    chk("pre_rst_e5", a0, 32'hDEADBEEF);
    step(0, 0, 0, 0, 0, 5, 31);
    chk("pre_rst_e31", b0, 32'h31313131);
    #2 rst_in = 1;
    #1;
    chk("rst_mid_a", a0, 0);
    chk("rst_mid_b", b0, 0);
    chk("rst_mid_busy", 32'(bz0), 0);
    @(negedge clk); rst_in = 0;

    for (int i = 0; i < 8; i++) begin
      step(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].be, 0, vecs[i].ra, vecs[i].rb);
      chk($sformatf("vec%0d_a_byp", i), a0, vecs[i].ea0);
      chk($sformatf("vec%0d_b_byp", i), b0, vecs[i].eb0);
      chk($sformatf("vec%0d_a_nobyp", i), a1, vecs[i].ea1);
      chk($sformatf("vec%0d_b_nobyp", i), b1, vecs[i].eb1);
      chk($sformatf("vec%0d_drop", i), 32'(dr0), 0);
    end

    step(1, 28, 32'hABCDEF01, 4'hF, 0, 28, 28);
    chk("d24_oor_wr_cycle", a2, 0);
    chk("d24_oor_drop", 32'(dr2), 0);
    step(0, 0, 0, 0, 0, 28, 28);
    chk("d24_oor_read", a2, 0);
    chk("d32_e28", a0, 32'hABCDEF01);

    for (int i = 0; i < 32; i++) step(1, 5'(i), 32'(i + 1), 4'hF, 0, 0, 0);
    step(0, 0, 0, 0, 0, 4, 23);
    chk("fill_e4", a0, 5);
    chk("fill_d24_e23", b2, 24);
    // clear request and write in the same idle cycle: write lands, then gets swept
    step(1, 10, 32'h77, 4'hF, 1, 0, 0);
    cnt0 = 0; cnt2 = 0;
    for (int c = 1; c <= 100; c++) begin
      step(0, 0, 0, 0, 0, c == 1 ? 5'd10 : c == 5 ? 5'd3 : 5'd0, c == 5 ? 5'd4 : 5'd0);
      if (!bz0 && !bz2) break;
      if (c == 1) chk("sweep_wr_landed", a0, 32'h77);
      if (c == 5) begin
        chk("sweep4_e3", a0, 0);
        chk("sweep4_e4", b0, 5);
      end
      if (c == 100) chk("sweep1_timeout", 1, 0);
      cnt0 += int'(bz0);
      cnt2 += int'(bz2);
    end
    chk("sweep1_busy_cycles", cnt0, 32);
    chk("d24_busy_cycles", cnt2, 24);
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 0, 0, 0, 5'(i), 5'(i));
      chk($sformatf("swept_e%0d", i), a0, 0);
      chk($sformatf("swept_nozero_e%0d", i), b1, 0);
      if (i < 24) chk($sformatf("swept_d24_e%0d", i), a2, 0);
    end

    for (int i = 0; i < 32; i++) step(1, 5'(i), 32'(i + 1), 4'hF, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    cnt0 = 0;
    for (int c = 1; c <= 100; c++) begin
      step(c == 3, 20, 32'h55, 4'hF, c == 6, (c == 3 || c == 10 || c == 25) ? 5'd20 : 5'd0, 0);
      if (!bz0) break;
      if (c == 3) begin
        chk("busy_wr_drop", 32'(dr0), 1);
        chk("busy_wr_nobypass", a0, 21);
      end
      if (c == 10) chk("busy_wr_unchanged", a0, 21);
      if (c == 25) chk("e20_swept", a0, 0);
      if (c == 100) chk("sweep2_timeout", 1, 0);
      cnt0 += int'(bz0);
    end
    chk("sweep2_busy_cycles", cnt0, 32);

    step(0, 0, 0, 0, 1, 0, 0);
    for (int c = 0; c < 5; c++) step(0, 0, 0, 0, 0, 0, 0);
    chk("sweep3_running", 32'(bz0), 1);
    #2 rst_in = 1;
    #1;
    chk("rst_abort_busy", 32'(bz0), 0);
    chk("rst_abort_busy_d24", 32'(bz2), 0);
    @(negedge clk); rst_in = 0;
    step(0, 0, 0, 0, 0, 30, 30);
    chk("after_abort_busy", 32'(bz0), 0);
    chk("after_abort_e30", a0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the single-write, dual-read register file used by the datapath.
- Adds configurable width and depth, per-byte write enables, and optional write-to-read bypass.
- Optional hardwired zero register.
- Adds a sequential clear engine that sweeps the array one entry per cycle with a Busy handshake, so software can clear the file without asserting Reset.

Parameters:
- DATA_W, 32: entry width in bits; must be a multiple of 8.
- ADDR_W, 5: address width.
- DEPTH, 32: number of entries; must satisfy DEPTH <= 2**ADDR_W.
- ZERO_REG, 1: when 1, entry 0 always reads 0 and writes to it are discarded.
- BYPASS, 1: when 1, a same-cycle write is forwarded to a matching read port.

Ports:
- clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high; clears the whole array and the FSM.
- R_Addr_A  in  ADDR_W  read port A address.
- R_Addr_B  in  ADDR_W  read port B address.
- R_Data_A  out  DATA_W  read port A data (combinational).
- R_Data_B  out  DATA_W  read port B data (combinational).
- Write_Reg  in  1  write strobe.
- W_Addr  in  ADDR_W  write address.
- W_Data  in  DATA_W  write data.
- W_Byte_En  in  DATA_W/8  per-byte write enable; bit i covers W_Data[8i+7:8i].
- Clear_Req  in  1  single-cycle request to start a sweep clear.
- Busy  out  1  high while the clear sweep is running.
- Wr_Drop  out  1  combinational flag: a write this cycle is being discarded because Busy is high.

Behaviour:
- Reset (async, active-high): all DEPTH entries = 0, FSM = IDLE, clear pointer = 0, Busy = 0. Reads during Reset return 0. Reset asserted mid-sweep aborts the sweep immediately.

Writes:
- Take effect on the rising edge of clk when Write_Reg=1, Busy=0, and W_Addr < DEPTH.
- Only bytes with W_Byte_En[i]=1 are updated; other bytes keep their old value.
- W_Byte_En = 0 is a legal no-op.
- Writes with W_Addr >= DEPTH are ignored.
- With ZERO_REG=1, writes to address 0 are ignored and do not raise Wr_Drop.

Reads:
- Combinational, zero latency.
- Address >= DEPTH reads 0.
- With ZERO_REG=1, address 0 reads 0.
- Bypass (BYPASS=1): if Write_Reg=1, Busy=0, W_Addr==R_Addr_x, and the write is not discarded, then R_Data_x = merge(stored, W_Data, W_Byte_En), i.e. enabled bytes from W_Data and the remaining bytes from stored.
- Without bypass (BYPASS=0): the read returns the pre-write value; the new value is visible the cycle after the edge.

Clear FSM, states IDLE and CLEAR:
- IDLE: Clear_Req=1 at a rising edge -> CLEAR with ptr=0.
- CLEAR: on each edge, entry[ptr] is set to 0 and ptr increments. On the edge where ptr==DEPTH-1, that last entry is cleared and the FSM returns to IDLE with ptr=0.
- Busy is asserted for exactly DEPTH cycles, starting the cycle after Clear_Req is sampled.
- Clear_Req while Busy: ignored (no restart, no queueing).
- Clear_Req and Write_Reg in the same cycle while IDLE: the write is performed, then the sweep begins next cycle and clears it.
- Write_Reg while Busy: no array update, Wr_Drop=1 that cycle, and no bypass.
- Reads during CLEAR return current contents: entries already swept read 0, unswept entries read their old values.

Width rules:
- Address comparisons use the full ADDR_W bits.
- ptr is ADDR_W bits wide and never exceeds DEPTH-1.

Test Plan:
1. Assert Reset mid-operation after writing 0xDEADBEEF to entry 5, then read A=5, B=31 -> both 0x00000000; Busy=0.
2. Write entry 3 = 0x11223344 (byte enable 0xF), then entry 3 with W_Data=0xAABBCCDD and byte enable 0b0101 -> next cycle read 3 = 0x11BB33DD. In the write cycle itself, R_Addr_A=3 with BYPASS=1 reads 0x11BB33DD; with BYPASS=0 it reads 0x11223344.
3. ZERO_REG=1: write 0xFFFFFFFF to entry 0 -> reads 0 on both ports, Wr_Drop=0. With ZERO_REG=0 the same write reads back 0xFFFFFFFF.
4. Fill all 32 entries with value = index+1, then pulse Clear_Req:
   - Busy is high for exactly 32 cycles.
   - On the cycle after the 4th clearing edge, entries 0-3 read 0 and entry 4 reads 5.
   - After Busy falls, all 32 entries read 0.
5. Mid-sweep:
   - Write_Reg to entry 20 with 0x55 -> Wr_Drop=1 that cycle and entry 20 stays unchanged until swept.
   - A second Clear_Req during Busy does not extend Busy beyond 32 cycles.
   - Asserting Reset mid-sweep drops Busy to 0 immediately.
6. DEPTH=24, ADDR_W=5: write to address 28 is ignored; read of address 28 returns 0; the sweep clears entries 0-23 and Busy is high for 24 cycles.
